// File: rtl/ppu_issue_ctrl.sv
// Issue controller between the zeroriscy ID stage and the posit processing unit.
// Optional DIV support is compiled in when the PPU_DIV_EN macro is defined.
module ppu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_rdata_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            illegal_insn_o,
  output logic            ppu_valid_o,
  input  logic            ppu_ready_i,
  output logic [2:0]      ppu_op_o,
  output logic [XLEN-1:0] ppu_a_o,
  output logic [XLEN-1:0] ppu_b_o,
  input  logic            ppu_result_valid_i,
  input  logic [XLEN-1:0] ppu_result_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            instr_done_o,
  output logic            timeout_o
);

  localparam logic [6:0] OPCODE_PPU_OP = 7'b0001011;
  localparam int         CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic       is_ppu;
  logic       dec_legal;
  logic [2:0] dec_op;
  logic       accept;
  logic       timeout_hit;

  // rs1/rs2 fields are not needed: operands arrive already read from the register file
  logic unused_rs_fields;
  assign unused_rs_fields = ^instr_rdata_i[24:15];

  assign is_ppu = instr_valid_i && (instr_rdata_i[6:0] == OPCODE_PPU_OP);

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = 3'd0;
    case ({instr_rdata_i[31:25], instr_rdata_i[14:12]})
      10'b1101010_000: dec_op = 3'd0;
      10'b1101010_001: dec_op = 3'd1;
      10'b1101010_010: dec_op = 3'd2;
`ifdef PPU_DIV_EN
      10'b1101010_100: dec_op = 3'd3;
`endif
      10'b1101000_000: dec_op = 3'd4;
      10'b1101001_000: dec_op = 3'd5;
      default:         dec_legal = 1'b0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && is_ppu && dec_legal && !flush_i && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    res_d       = res_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = dec_op;
          a_d     = operand_a_i;
          b_d     = operand_b_i;
          rd_d    = instr_rdata_i[11:7];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A handshake in the same cycle as a flush still commits the request
        if (ppu_ready_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (ppu_result_valid_i) begin
          res_d   = ppu_result_i;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
    end
  end

  assign stall_o        = (state_q != S_IDLE) || accept;
  assign illegal_insn_o = (state_q == S_IDLE) && is_ppu && !dec_legal && !rst;
  assign timeout_o      = timeout_hit && !rst;
  assign ppu_valid_o    = (state_q == S_ISSUE);
  assign ppu_op_o       = op_q;
  assign ppu_a_o        = a_q;
  assign ppu_b_o        = b_q;
  assign rf_we_o        = (state_q == S_WB) && (rd_q != 5'd0);
  assign rf_waddr_o     = rd_q;
  assign rf_wdata_o     = res_q;
  assign instr_done_o   = (state_q == S_WB);

endmodule
